// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master among N_REQ requesters; SPI_ARB_TIMEOUT_EN adds a WAIT abort (err with ack).
// Latency: req->spi_start 2 cycles, spi_done rising edge->ack 2 cycles; requesters hold req/data until their ack.
module spi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     err,
    output logic                     spi_start,
    output logic [DATA_W-1:0]        spi_data,
    input  logic                     spi_done,
    output logic [N_REQ-1:0]         dev_sel,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  pick;
    logic              pick_vld;
    logic [N_REQ-1:0]  pick_oh;
    logic [DATA_W-1:0] req_bytes [N_REQ];
    logic              done_s;
    logic              done_q;
    logic              done_rise;
    logic              wait_expired;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_bytes[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // First pending requester at or after the pointer, wrapping around.
    always_comb begin : arbitrate
        logic [IDX_W-1:0] idx;
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
    end

    // Done is sampled once more before edge detection, so a level left high by a previous transfer never counts.
    assign done_rise = done_s & ~done_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else if (state == S_START) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else if (state == S_WAIT) begin
            wait_cnt  <= wait_cnt + 1'b1;
            timed_out <= wait_expired && !done_rise;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (|req) state_nxt = S_GRANT;
            S_GRANT: state_nxt = pick_vld ? S_START : S_IDLE;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (done_rise || wait_expired) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr      <= '0;
            grant_id <= '0;
            spi_data <= '0;
            dev_sel  <= '0;
            done_s   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_s <= spi_done;
            done_q <= done_s;
            case (state)
                S_GRANT: begin
                    if (pick_vld) begin
                        grant_id <= pick;
                        spi_data <= req_bytes[pick];
                        dev_sel  <= pick_oh;
                    end
                end
                S_ACK: begin
                    ptr     <= (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                    dev_sel <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack       = '0;
        err       = 1'b0;
        spi_start = (state == S_START);
        busy      = (state != S_IDLE);
        if (state == S_ACK) begin
            ack[grant_id] = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
            err = timed_out;
`endif
        end
    end

endmodule
